// File: rtl/data_stack.sv
// Operand stack feeding the brus16 ALU: tos/nos are the operands and BINOP folds the result back in.
// Optional debug read port enabled by defining DSTACK_DEBUG_EN.
module data_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 cmd,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [PTR_W-1:0]           count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
`ifdef DSTACK_DEBUG_EN
  ,
  input  logic [$clog2(DEPTH)-1:0]   dbg_addr,
  output logic [WIDTH-1:0]           dbg_data
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CmdNop   = 3'd0,
    CmdPush  = 3'd1,
    CmdPop   = 3'd2,
    CmdBinop = 3'd3,
    CmdSwap  = 3'd4,
    CmdDup   = 3'd5,
    CmdOver  = 3'd6,
    CmdRsvd  = 3'd7
  } cmd_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic             err_q, err_d;

  logic [AW-1:0]    idx_top, idx_nos, idx_new;
  logic [WIDTH-1:0] top_raw, nos_raw;
  logic             has1, has2, room;

  // Two write ports: SWAP is the only command that needs both.
  logic             we_a, we_b;
  logic [AW-1:0]    addr_a, addr_b;
  logic [WIDTH-1:0] data_a, data_b;

  assign idx_new = sp_q[AW-1:0];
  assign idx_top = sp_q[AW-1:0] - AW'(1);
  assign idx_nos = sp_q[AW-1:0] - AW'(2);
  assign top_raw = mem_q[idx_top];
  assign nos_raw = mem_q[idx_nos];

  assign has1 = (sp_q >= PTR_W'(1));
  assign has2 = (sp_q >= PTR_W'(2));
  assign room = (sp_q < PTR_W'(DEPTH));

  always_comb begin
    sp_d   = sp_q;
    err_d  = err_q;
    we_a   = 1'b0;
    we_b   = 1'b0;
    addr_a = idx_new;
    addr_b = idx_nos;
    data_a = din;
    data_b = top_raw;
    unique case (cmd_e'(cmd))
      CmdPush: begin
        if (room) begin
          we_a = 1'b1;
          sp_d = sp_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      CmdPop: begin
        if (has1) sp_d = sp_q - PTR_W'(1);
        else      err_d = 1'b1;
      end
      CmdBinop: begin
        if (has2) begin
          we_a   = 1'b1;
          addr_a = idx_nos;
          sp_d   = sp_q - PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      CmdSwap: begin
        if (has2) begin
          we_a   = 1'b1;
          addr_a = idx_top;
          data_a = nos_raw;
          we_b   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      CmdDup: begin
        if (has1 && room) begin
          we_a   = 1'b1;
          data_a = top_raw;
          sp_d   = sp_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      CmdOver: begin
        if (has2 && room) begin
          we_a   = 1'b1;
          data_a = nos_raw;
          sp_d   = sp_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      CmdNop, CmdRsvd: ;
      default: ;
    endcase
    // Reset aborts whatever the decode stage asked for this cycle.
    if (reset) begin
      we_a = 1'b0;
      we_b = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_a) mem_q[addr_a] <= data_a;
    if (we_b) mem_q[addr_b] <= data_b;
  end

  assign tos   = has1 ? top_raw : '0;
  assign nos   = has2 ? nos_raw : '0;
  assign count = sp_q;
  assign full  = (sp_q == PTR_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign err   = err_q;

`ifdef DSTACK_DEBUG_EN
  assign dbg_data = mem_q[dbg_addr];
`endif

endmodule
